// File: rtl/cbb_ones_index_emitter_pkg.sv
// Shared CBB definitions: width derivation helpers (common with the popcount block)
// and the emitter state encoding.
package cbb_ones_index_emitter_pkg;

  localparam int CBB_DEFAULT_WIDTH = 8;

  // Index width for a bitmap of the given width.
  function automatic int cbb_idx_w(input int width);
    return $clog2(width);
  endfunction

  // Count/rank width: wide enough to hold a full popcount of the bitmap.
  function automatic int cbb_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } cbb_state_t;

endpackage

// File: rtl/cbb_ones_index_emitter_lsb_onehot_finder.sv
// Combinational lowest-set-bit finder: index, one-hot mask and an exactly-one-set flag.
module cbb_lsb_onehot_finder
  import cbb_ones_index_emitter_pkg::*;
#(
  parameter int WIDTH = CBB_DEFAULT_WIDTH,
  localparam int IDX_W = cbb_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot,
  output logic             single
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (~vec + WIDTH'(1));
  assign single = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cbb_ones_index_emitter.sv
// Expands an accepted bitmap into an LSB-first stream of set-bit indices,
// one per handshake, tagged with rank, last and an all-zero bitmap marker.
//
// state   | meaning
// IDLE    | no bitmap held; in_ready=1, out_valid=0
// EMIT    | residue holds the not-yet-emitted bits; one beat presented per cycle
module cbb_ones_index_emitter
  import cbb_ones_index_emitter_pkg::*;
#(
  parameter int WIDTH = CBB_DEFAULT_WIDTH,
  localparam int IDX_W = cbb_idx_w(WIDTH),
  localparam int OUT_CNT_W = cbb_cnt_w(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [OUT_CNT_W-1:0] out_rank,
  output logic                 out_last,
  output logic                 out_zero
);

  cbb_state_t           state;
  logic [WIDTH-1:0]     residue;
  logic [WIDTH-1:0]     lsb_onehot;
  logic [IDX_W-1:0]     lsb_idx;
  logic                 lsb_single;
  logic [OUT_CNT_W-1:0] rank;
  logic                 emit;
  logic                 res_zero;
  logic                 xfer;
  logic                 accept;

  cbb_lsb_onehot_finder #(.WIDTH(WIDTH)) u_finder (
    .vec    (residue),
    .idx    (lsb_idx),
    .onehot (lsb_onehot),
    .single (lsb_single)
  );

  // Outputs decode straight from registered state, so they hold under backpressure.
  assign emit      = (state == ST_EMIT);
  assign res_zero  = (residue == '0);
  assign out_valid = emit;
  assign out_idx   = lsb_idx;
  assign out_rank  = rank;
  assign out_last  = emit & (lsb_single | res_zero);
  assign out_zero  = emit & res_zero;

  assign xfer     = out_valid & out_ready;
  assign in_ready = ~emit | (xfer & out_last);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      residue <= '0;
      rank    <= '0;
    end else if (accept) begin
      // Covers both a fresh start and a new bitmap landing on the last beat.
      state   <= ST_EMIT;
      residue <= data_in;
      rank    <= '0;
    end else if (xfer) begin
      residue <= residue & ~lsb_onehot;
      if (out_last) begin
        state <= ST_IDLE;
        rank  <= '0;
      end else begin
        rank <= rank + OUT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cbb_ones_index_emitter.sv
// Self-checking bench for cbb_ones_index_emitter (WIDTH=8): directed table, corner sequences
// and random bitmaps checked against a queue-based beat model.
module tb_cbb_ones_index_emitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [3:0] out_rank;
  logic       out_last;
  logic       out_zero;

  cbb_ones_index_emitter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_rank  (out_rank),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int rank;
    bit last;
    bit zero;
    int cyc;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    int         first_idx;
    int         beats;
    int         last_idx;
    bit         zero;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_total = 0;

  beat_t      exp_q[$];
  beat_t      log_q[$];
  logic [7:0] bm_q[$];
  int         acc_log[$];

  logic [7:0] or_acc = '0;
  int         bm_cnt = 0;
  int         prev_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected beats of a bitmap, derived directly from its set bits.
  task automatic push_bitmap(input logic [7:0] b);
    int pc;
    int n;
    beat_t e;
    pc = $countones(b);
    n = 0;
    if (pc == 0) begin
      e = '{0, 0, 1'b1, 1'b1, 0};
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (b[i]) begin
          e = '{i, n, (n == pc - 1), 1'b0, 0};
          exp_q.push_back(e);
          n++;
        end
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t      b;
    logic [7:0] cur;
    bit         exp_valid;
    int         want;
    if (rst_n) begin
      exp_valid = (exp_q.size() > 0);
      check("out_valid", int'(out_valid), int'(exp_valid));
      check("in_ready", int'(in_ready), int'(!exp_valid || (out_ready && exp_q[0].last)));
      if (out_valid && out_ready && exp_valid) begin
        b = exp_q.pop_front();
        check("beat_idx", int'(out_idx), b.idx);
        check("beat_rank", int'(out_rank), b.rank);
        check("beat_last", int'(out_last), int'(b.last));
        check("beat_zero", int'(out_zero), int'(b.zero));
        if (bm_cnt > 0) check("idx_increasing", int'(int'(out_idx) > prev_idx), 1);
        if (!out_zero) or_acc[out_idx] = 1'b1;
        bm_cnt++;
        prev_idx = int'(out_idx);
        log_q.push_back('{int'(out_idx), int'(out_rank), out_last, out_zero, cyc});
        if (b.last) begin
          cur = bm_q.pop_front();
          want = ($countones(cur) > 0) ? $countones(cur) : 1;
          check("beat_count", bm_cnt, want);
          check("or_equals_bitmap", int'(or_acc), int'(cur));
          or_acc = '0;
          bm_cnt = 0;
        end
      end
      if (in_valid && in_ready) begin
        push_bitmap(data_in);
        bm_q.push_back(data_in);
        acc_log.push_back(cyc);
        acc_total++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_one(input logic [7:0] b);
    int k;
    in_valid = 1'b1;
    data_in = b;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    tick();
    in_valid = 1'b0;
    data_in = $urandom;
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  vec_t tbl[6];

  initial begin
    int k;
    int start;

    tbl[0] = '{8'h01, 0, 1, 0, 1'b0};
    tbl[1] = '{8'h80, 7, 1, 7, 1'b0};
    tbl[2] = '{8'hFF, 0, 8, 7, 1'b0};
    tbl[3] = '{8'h00, 0, 1, 0, 1'b1};
    tbl[4] = '{8'h0C, 2, 2, 3, 1'b0};
    tbl[5] = '{8'h91, 0, 3, 7, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    out_ready = 1'b1;
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_rank", int'(out_rank), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_zero", int'(out_zero), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Directed table, out_ready held high.
    for (int t = 0; t < 6; t++) begin
      log_q.delete();
      accept_one(tbl[t].data);
      run_until_idle(30);
      check("tbl_beats", log_q.size(), tbl[t].beats);
      if (log_q.size() > 0) begin
        check("tbl_first_idx", log_q[0].idx, tbl[t].first_idx);
        check("tbl_last_idx", log_q[log_q.size()-1].idx, tbl[t].last_idx);
        check("tbl_zero", int'(log_q[0].zero), int'(tbl[t].zero));
      end
    end

    // Reset mid-stream.
    out_ready = 1'b1;
    accept_one(8'hFF);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_idx", int'(out_idx), 0);
    check("midrst_out_rank", int'(out_rank), 0);
    check("midrst_out_last", int'(out_last), 0);
    check("midrst_out_zero", int'(out_zero), 0);
    exp_q.delete();
    bm_q.delete();
    or_acc = '0;
    bm_cnt = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    log_q.delete();
    accept_one(8'h01);
    run_until_idle(30);
    check("postrst_beats", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("postrst_idx", log_q[0].idx, 0);
      check("postrst_rank", log_q[0].rank, 0);
      check("postrst_last", int'(log_q[0].last), 1);
    end

    // Sparse bitmap, consecutive beats.
    log_q.delete();
    accept_one(8'hAA);
    run_until_idle(30);
    check("sparse_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("sparse_idx", log_q[i].idx, 2 * i + 1);
        check("sparse_rank", log_q[i].rank, i);
        check("sparse_last", int'(log_q[i].last), int'(i == 3));
        if (i > 0) check("sparse_consecutive", log_q[i].cyc - log_q[i-1].cyc, 1);
      end
    end
    check("sparse_in_ready_after", int'(in_ready), 1);

    // Backpressure: stall on idx 4, then toggle out_ready.
    log_q.delete();
    out_ready = 1'b0;
    accept_one(8'hF0);
    repeat (4) begin
      @(negedge clk);
      check("stall_idx", int'(out_idx), 4);
      check("stall_rank", int'(out_rank), 0);
      check("stall_last", int'(out_last), 0);
      @(posedge clk);
      #1;
    end
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      out_ready = ~out_ready;
      tick();
      k++;
    end
    if (exp_q.size() != 0) check("bp_timeout", exp_q.size(), 0);
    check("bp_beats", log_q.size(), 4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) check("bp_idx", log_q[i].idx, 4 + i);
    out_ready = 1'b1;

    // Back-to-back bitmaps, second accept lands on the last beat of the first.
    log_q.delete();
    acc_log.delete();
    in_valid = 1'b1;
    data_in = 8'h81;
    tick();
    data_in = 8'h40;
    k = 0;
    while (acc_log.size() < 2 && k < 10) begin
      tick();
      k++;
    end
    in_valid = 1'b0;
    run_until_idle(30);
    check("b2b_beats", log_q.size(), 3);
    if (log_q.size() == 3 && acc_log.size() == 2) begin
      check("b2b_idx0", log_q[0].idx, 0);
      check("b2b_idx1", log_q[1].idx, 7);
      check("b2b_idx2", log_q[2].idx, 6);
      check("b2b_gap01", log_q[1].cyc - log_q[0].cyc, 1);
      check("b2b_gap12", log_q[2].cyc - log_q[1].cyc, 1);
      check("b2b_accept_on_last", acc_log[1], log_q[1].cyc);
    end else begin
      check("b2b_accepts", acc_log.size(), 2);
    end

    // Random bitmaps with random out_ready.
    start = acc_total;
    k = 0;
    while (acc_total < start + 1000 && k < 40000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      data_in = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    if (acc_total < start + 1000) check("rand_timeout", acc_total - start, 1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    run_until_idle(50);
    check("rand_all_drained", bm_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
